// File: rtl/nbody_pkg.sv
// Shared types and constants for the n-body gravity datapath: IEEE-754 doubles,
// body records, pair tags and the scheduler state encoding.
package nbody_pkg;

  localparam int BODY_IDX_W      = 9;
  localparam int GETACCL_LATENCY = 122;

  typedef logic [63:0]           fp64_t;
  typedef logic [BODY_IDX_W-1:0] idx_t;

  typedef struct packed {
    fp64_t x;
    fp64_t y;
    fp64_t m;
  } body_t;

  typedef struct packed {
    logic valid;
    idx_t i;
    logic last;
  } pair_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth, stall-free shift register used to align pair tags with a
// pipelined arithmetic unit. Reset clears every stage so no stale tag escapes.
module tag_delay_line #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 122
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is reset, not just the output; a flushed line is what
  // guarantees no tag_valid survives an abandoned run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/accl_pair_scheduler.sv
// Walks every ordered body pair (i,j), i!=j, out of the body RAM at one pair per
// cycle for getAccl, and delays a {valid,i,last} tag to line up with its result.
module accl_pair_scheduler
  import nbody_pkg::*;
#(
  parameter int IDX_W   = 9,
  parameter int LATENCY = GETACCL_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W:0]   n_bodies,
  output logic             busy,
  output logic             done,
  output logic             mem_rd_en,
  output logic [IDX_W-1:0] mem_addr,
  input  fp64_t            mem_x,
  input  fp64_t            mem_y,
  input  fp64_t            mem_m,
  output fp64_t            x1,
  output fp64_t            y1,
  output fp64_t            x2,
  output fp64_t            y2,
  output fp64_t            m2,
  output logic             pair_valid,
  output logic             tag_valid,
  output logic [IDX_W-1:0] tag_i,
  output logic             tag_last
);

  localparam int CNT_W   = IDX_W + 1;
  localparam int DRAIN_W = $clog2(LATENCY + 2);
  localparam int TAG_W   = IDX_W + 2;

  sched_state_e       state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic               fetch_i_q, fetch_i_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic [CNT_W-1:0]   j_inc;
  logic               j_last;
  logic               rd_is_i, rd_is_j, rd_last;

  // Read tag travelling with the 1-cycle RAM access.
  logic               rd_is_i_q, rd_is_j_q, rd_last_q;
  logic [IDX_W-1:0]   rd_i_q;

  fp64_t              xi_hold_q, yi_hold_q;
  body_t              pair_j_q;
  fp64_t              x1_q, y1_q;
  logic               pair_valid_q, pair_last_q;
  logic [IDX_W-1:0]   pair_i_q;
  logic [TAG_W-1:0]   tag_out;

  // Next j skips the diagonal; the extra bit keeps n = 2**IDX_W from wrapping.
  always_comb begin
    j_inc = {1'b0, j_q} + CNT_W'(1);
    if (j_inc == {1'b0, i_q}) j_inc = j_inc + CNT_W'(1);
    j_last = (j_inc >= n_q);
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    i_d       = i_q;
    j_d       = j_q;
    fetch_i_d = fetch_i_q;
    drain_d   = drain_q;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    rd_is_i   = 1'b0;
    rd_is_j   = 1'b0;
    rd_last   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d = n_bodies;
          if (n_bodies < CNT_W'(2)) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_ISSUE;
            i_d       = '0;
            j_d       = IDX_W'(1);
            fetch_i_d = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        if (fetch_i_q) begin
          mem_addr  = i_q;
          rd_is_i   = 1'b1;
          fetch_i_d = 1'b0;
        end else begin
          mem_addr = j_q;
          rd_is_j  = 1'b1;
          rd_last  = j_last;
          if (!j_last) begin
            j_d = j_inc[IDX_W-1:0];
          end else if ({1'b0, i_q} == n_q - CNT_W'(1)) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            i_d       = i_q + IDX_W'(1);
            j_d       = '0;
            fetch_i_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_q == DRAIN_W'(LATENCY + 1)) state_d = ST_DONE;
        else                                  drain_d = drain_q + DRAIN_W'(1);
      end

      ST_DONE: begin
        done    = 1'b1;
        busy    = (n_q >= CNT_W'(2));
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      fetch_i_q <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      i_q       <= i_d;
      j_q       <= j_d;
      fetch_i_q <= fetch_i_d;
      drain_q   <= drain_d;
    end
  end

  // Data returns one cycle after the read; the tag tells us what it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_is_i_q    <= 1'b0;
      rd_is_j_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_i_q       <= '0;
      xi_hold_q    <= '0;
      yi_hold_q    <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      pair_j_q     <= '0;
      pair_valid_q <= 1'b0;
      pair_i_q     <= '0;
      pair_last_q  <= 1'b0;
    end else begin
      rd_is_i_q <= rd_is_i;
      rd_is_j_q <= rd_is_j;
      rd_last_q <= rd_last;
      rd_i_q    <= i_q;
      if (rd_is_i_q) begin
        xi_hold_q <= mem_x;
        yi_hold_q <= mem_y;
      end
      pair_valid_q <= rd_is_j_q;
      if (rd_is_j_q) begin
        x1_q        <= xi_hold_q;
        y1_q        <= yi_hold_q;
        pair_j_q    <= '{x: mem_x, y: mem_y, m: mem_m};
        pair_i_q    <= rd_i_q;
        pair_last_q <= rd_last_q;
      end else begin
        x1_q        <= '0;
        y1_q        <= '0;
        pair_j_q    <= '0;
        pair_i_q    <= '0;
        pair_last_q <= 1'b0;
      end
    end
  end

  tag_delay_line #(
    .WIDTH(TAG_W),
    .DEPTH(LATENCY)
  ) u_tag_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  ({pair_valid_q, pair_i_q, pair_last_q}),
    .q_o  (tag_out)
  );

  assign x1         = x1_q;
  assign y1         = y1_q;
  assign x2         = pair_j_q.x;
  assign y2         = pair_j_q.y;
  assign m2         = pair_j_q.m;
  assign pair_valid = pair_valid_q;
  assign tag_valid  = tag_out[TAG_W-1];
  assign tag_i      = tag_out[TAG_W-2:1];
  assign tag_last   = tag_out[0];

endmodule

// File: tb/tb_accl_pair_scheduler.sv
// Self-checking bench: body RAM model plus a cycle-indexed reference model that
// derives every expected output from pair ordering arithmetic.
module tb_accl_pair_scheduler;
  import nbody_pkg::*;

  localparam int IW  = 5;
  localparam int NB  = 1 << IW;
  localparam int LAT = GETACCL_LATENCY;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [IW-1:0] addr;
    logic          pv;
    logic [63:0]   x1, y1, x2, y2, m2;
    logic          tv;
    logic [IW-1:0] ti;
    logic          tl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW:0]   n_bodies = '0;
  logic          busy, done, mem_rd_en;
  logic [IW-1:0] mem_addr;
  fp64_t         mem_x = '0, mem_y = '0, mem_m = '0;
  fp64_t         x1, y1, x2, y2, m2;
  logic          pair_valid, tag_valid, tag_last;
  logic [IW-1:0] tag_i;

  fp64_t ram_x [NB];
  fp64_t ram_y [NB];
  fp64_t ram_m [NB];

  int checks = 0;
  int errors = 0;
  int cur_cycle = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_x <= ram_x[mem_addr];
      mem_y <= ram_y[mem_addr];
      mem_m <= ram_m[mem_addr];
    end
  end

  accl_pair_scheduler #(.IDX_W(IW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_bodies(n_bodies),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_x(mem_x), .mem_y(mem_y), .mem_m(mem_m),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .m2(m2),
    .pair_valid(pair_valid), .tag_valid(tag_valid), .tag_i(tag_i), .tag_last(tag_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cur_cycle, obs, exp);
    end
  endtask

  // Cycle c counts from the edge that samples start (c=1 just after it).
  // Pair (i, k-th j) lands at i*n + k + 4; its tag LAT cycles later.
  function automatic exp_t model(input int n, input int c);
    exp_t e;
    int t, r, i, k, j;
    e = '0;
    t = n * n;
    if (n < 2) begin
      e.done = (c == 1);
      return e;
    end
    e.busy = (c >= 1) && (c <= t + 3 + LAT);
    e.done = (c == t + 3 + LAT);
    if (c >= 1 && c <= t) begin
      r = c - 1; i = r / n; k = r % n;
      e.rd_en = 1'b1;
      e.addr  = IW'((k == 0) ? i : ((k - 1 < i) ? k - 1 : k));
    end
    r = c - 4;
    if (r >= 0 && r < t && (r % n) <= n - 2) begin
      i = r / n; k = r % n; j = (k < i) ? k : k + 1;
      e.pv = 1'b1;
      e.x1 = ram_x[i]; e.y1 = ram_y[i];
      e.x2 = ram_x[j]; e.y2 = ram_y[j]; e.m2 = ram_m[j];
    end
    r = c - 4 - LAT;
    if (r >= 0 && r < t && (r % n) <= n - 2) begin
      e.tv = 1'b1;
      e.ti = IW'(r / n);
      e.tl = ((r % n) == n - 2);
    end
    return e;
  endfunction

  task automatic check_all(input exp_t e);
    check("busy",       64'(busy),       64'(e.busy));
    check("done",       64'(done),       64'(e.done));
    check("mem_rd_en",  64'(mem_rd_en),  64'(e.rd_en));
    check("mem_addr",   64'(mem_addr),   64'(e.addr));
    check("pair_valid", 64'(pair_valid), 64'(e.pv));
    check("x1", x1, e.x1);
    check("y1", y1, e.y1);
    check("x2", x2, e.x2);
    check("y2", y2, e.y2);
    check("m2", m2, e.m2);
    check("tag_valid",  64'(tag_valid),  64'(e.tv));
    check("tag_i",      64'(tag_i),      64'(e.ti));
    check("tag_last",   64'(tag_last),   64'(e.tl));
    if (pair_valid === 1'b1)
      check("self_pair", 64'((x1 == x2) && (y1 == y2)), 64'(0));
  endtask

  // One run of n bodies, checked every cycle through the first IDLE cycle.
  // abort_c > 0 pulls reset low in that cycle and stops checking the run there.
  task automatic run(input int n, input bit hold, input int abort_c);
    int done_c, last_c;
    done_c = (n < 2) ? 1 : n * n + 3 + LAT;
    last_c = done_c + 1;
    n_bodies = (IW + 1)'(n);
    start    = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      cur_cycle = c;
      if (!hold || c == done_c) start = 1'b0;
      check_all(model(n, c));
      if (c == abort_c) begin
        rst_n = 1'b0;
        #1;
        check_all('0);
        return;
      end
    end
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < NB; k++) begin
      ram_x[k] = {$urandom(), $urandom()};
      ram_y[k] = {$urandom(), $urandom()};
      ram_m[k] = {$urandom(), $urandom()};
      ram_x[k][IW-1:0] = k[IW-1:0];
    end
  endtask

  initial begin
    for (int k = 0; k < NB; k++) begin
      ram_x[k] = '0; ram_y[k] = '0; ram_m[k] = '0;
    end
    repeat (3) @(negedge clk);
    cur_cycle = 0;
    check_all('0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all('0);

    // Three bodies: (0,0,500), (10,20,400), (10,-10,300).
    ram_x[0] = 64'h0000000000000000; ram_y[0] = 64'h0000000000000000; ram_m[0] = 64'h407F400000000000;
    ram_x[1] = 64'h4024000000000000; ram_y[1] = 64'h4034000000000000; ram_m[1] = 64'h4079000000000000;
    ram_x[2] = 64'h4024000000000000; ram_y[2] = 64'hC024000000000000; ram_m[2] = 64'h4072C00000000000;
    run(3, 1'b0, 0);

    // Degenerate body counts.
    run(0, 1'b0, 0);
    run(1, 1'b0, 0);

    // Reset in the middle of an n=8 run, then a clean restart.
    fill_random(8);
    run(8, 1'b0, 60);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 8; c++) begin
      @(negedge clk);
      cur_cycle = c;
      check_all('0);
    end
    fill_random(3);
    run(3, 1'b0, 0);

    // start held high throughout: exactly one run.
    fill_random(4);
    run(4, 1'b1, 0);

    // Randomized body counts.
    repeat (3) begin
      fill_random(NB);
      run($urandom_range(2, 7), 1'b0, 0);
    end

    // Largest legal body count.
    fill_random(NB);
    run(NB, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
